// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier controller.
//   mult_state_e : FSM state encoding (IDLE / RUN / FIX / DONE)
//   cnt_width()  : iteration counter width for a given operand width,
//                  clog2(nbits)+1, so the counter can hold nbits itself.
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    function automatic int unsigned cnt_width(input int unsigned nbits);
        return $clog2(nbits) + 1;
    endfunction

endpackage

// File: rtl/Adder32bits.sv
// -----------------------------------------------------------------------------
// Adder32bits
// Plain combinational adder, width set by NBits (the name is historical; the
// multiplier instantiates it at NBits+1 so the carry out of the partial
// product accumulation is kept).
// Ports:
//   a_i   [NBits-1:0] : addend
//   b_i   [NBits-1:0] : addend
//   sum_o [NBits-1:0] : a_i + b_i, modulo 2**NBits
// -----------------------------------------------------------------------------
module Adder32bits #(
    parameter int NBits = 32
) (
    input  logic [NBits-1:0] a_i,
    input  logic [NBits-1:0] b_i,
    output logic [NBits-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/mult_controller.sv
// -----------------------------------------------------------------------------
// mult_controller
// Sequential shift-and-add multiplier, one partial-product bit per cycle.
// {Hi,Lo} acts as a 2*NBits shift register: Lo starts as the multiplier and
// its LSB selects whether the multiplicand is added into Hi each iteration.
//
// Optional feature macro: MULT_SIGNED_EN
//   When defined, port in_Signed is added. Signed operations multiply the
//   operand magnitudes and spend one FIX cycle negating the product when the
//   operand signs differ. Without the macro every operation is unsigned and
//   FIX is unreachable.
//
// Ports:
//   clk             : clock, all state changes on the rising edge
//   reset           : synchronous active-high reset
//   in_Start        : start request, honoured only in IDLE
//   in_Multiplicand : operand A, sampled on accepted start
//   in_Multiplier   : operand B, sampled on accepted start
//   in_Signed       : (MULT_SIGNED_EN only) two's-complement operation
//   out_Busy        : high in RUN and FIX
//   out_Done        : one-cycle completion pulse (DONE state)
//   out_Hi/out_Lo   : upper/lower product halves, valid from DONE until the
//                     next accepted start
// Latency: out_Done in cycle NBits+1 after the start edge (NBits+2 signed).
// -----------------------------------------------------------------------------
module mult_controller
    import mult_pkg::*;
#(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Start,
    input  logic [NBits-1:0] in_Multiplicand,
    input  logic [NBits-1:0] in_Multiplier,
`ifdef MULT_SIGNED_EN
    input  logic             in_Signed,
`endif
    output logic             out_Busy,
    output logic             out_Done,
    output logic [NBits-1:0] out_Hi,
    output logic [NBits-1:0] out_Lo
);

    localparam int CntW = int'(cnt_width(NBits));

    mult_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [NBits-1:0] mcand_q, mcand_d;
    logic [NBits-1:0] hi_q, hi_d;
    logic [NBits-1:0] lo_q, lo_d;

    logic             last_iter;
    logic             fix_needed;
    logic [NBits-1:0] op_a_mag;
    logic [NBits-1:0] op_b_mag;
    logic [NBits:0]   add_a;
    logic [NBits:0]   add_b;
    logic [NBits:0]   sum;

    assign last_iter = (cnt_q == CntW'(NBits - 1));

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
`ifdef MULT_SIGNED_EN
    logic sgn_q, sgn_d;   // operation runs through FIX
    logic neg_q, neg_d;   // product must be negated in FIX
    logic a_neg, b_neg;

    assign a_neg      = in_Signed & in_Multiplicand[NBits-1];
    assign b_neg      = in_Signed & in_Multiplier[NBits-1];
    // Magnitude of the most negative value wraps to itself, which is its
    // correct unsigned magnitude.
    assign op_a_mag   = a_neg ? (~in_Multiplicand + 1'b1) : in_Multiplicand;
    assign op_b_mag   = b_neg ? (~in_Multiplier + 1'b1) : in_Multiplier;
    assign fix_needed = sgn_q;
`else
    assign op_a_mag   = in_Multiplicand;
    assign op_b_mag   = in_Multiplier;
    assign fix_needed = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Single iteration adder, one bit wider to keep the carry
    // ------------------------------------------------------------------
    assign add_a = {1'b0, hi_q};
    assign add_b = lo_q[0] ? {1'b0, mcand_q} : '0;

    Adder32bits #(
        .NBits (NBits + 1)
    ) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (sum)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_Start) state_d = RUN;
            RUN:     if (last_iter) state_d = fix_needed ? FIX : DONE;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_Busy = 1'b0;
        out_Done = 1'b0;
        case (state_q)
            RUN, FIX: out_Busy = 1'b1;
            DONE:     out_Done = 1'b1;
            default:  ;
        endcase
    end

    assign out_Hi = hi_q;
    assign out_Lo = lo_q;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULT_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_Start) begin
                    mcand_d = op_a_mag;
                    hi_d    = '0;
                    lo_d    = op_b_mag;
                    cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                    sgn_d   = in_Signed;
                    neg_d   = a_neg ^ b_neg;
`endif
                end
            end
            RUN: begin
                // {sum, lo} >> 1: adder carry lands in the Hi MSB, the sum
                // LSB moves into the Lo MSB, the consumed multiplier bit drops.
                hi_d  = sum[NBits:1];
                lo_d  = {sum[0], lo_q[NBits-1:1]};
                cnt_d = cnt_q + CntW'(1);
            end
`ifdef MULT_SIGNED_EN
            FIX: begin
                if (neg_q) begin
                    {hi_d, lo_d} = ~{hi_q, lo_q} + 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULT_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mult_controller
// Directed, table-driven bench for mult_controller (NBits = 32). Cycle
// numbering: the edge that samples an accepted start ends cycle 0; cycle n
// is observed 1 ns after the n-th following rising edge.
// Build with MULT_SIGNED_EN defined to add the signed vectors.
// -----------------------------------------------------------------------------
module tb_mult_controller;

    localparam int NB = 32;

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic          sgn;
        logic          inject;   // try a 2 x 2 start in cycle 5
        logic [NB-1:0] exp_hi;
        logic [NB-1:0] exp_lo;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_Start;
    logic [NB-1:0] in_Multiplicand;
    logic [NB-1:0] in_Multiplier;
`ifdef MULT_SIGNED_EN
    logic          in_Signed;
`endif
    logic          out_Busy;
    logic          out_Done;
    logic [NB-1:0] out_Hi;
    logic [NB-1:0] out_Lo;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mult_controller #(
        .NBits (NB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_Start        (in_Start),
        .in_Multiplicand (in_Multiplicand),
        .in_Multiplier   (in_Multiplier),
`ifdef MULT_SIGNED_EN
        .in_Signed       (in_Signed),
`endif
        .out_Busy        (out_Busy),
        .out_Done        (out_Done),
        .out_Hi          (out_Hi),
        .out_Lo          (out_Lo)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_start(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic sgn);
        in_Multiplicand = a;
        in_Multiplier   = b;
        in_Start        = 1'b1;
`ifdef MULT_SIGNED_EN
        in_Signed       = sgn;
`else
        if (sgn) $display("note: signed vector requested in unsigned build");
`endif
    endtask

    // Starts an operation in the current cycle (caller is in an IDLE cycle)
    // and follows it through the first IDLE cycle after DONE.
    task automatic run_op(input vec_t v);
        int done_cnt;
        int done_cyc;
        int exp_cyc;
        done_cnt = 0;
        done_cyc = -1;
        exp_cyc  = v.sgn ? NB + 2 : NB + 1;
        drive_start(v.a, v.b, v.sgn);
        @(posedge clk); #1;
        in_Start = 1'b0;
        for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (out_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 1) check("busy_first_run", {63'd0, out_Busy}, 64'd1);
            if (v.inject && cyc == 5) drive_start(32'd2, 32'd2, 1'b0);
            if (v.inject && cyc == 6) in_Start = 1'b0;
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(exp_cyc));
        check("busy_in_done", {63'd0, out_Busy}, 64'd0);
        check("hi", {32'd0, out_Hi}, {32'd0, v.exp_hi});
        check("lo", {32'd0, out_Lo}, {32'd0, v.exp_lo});
        $display("op %08h x %08h sgn=%0d -> hi=%08h lo=%08h done_cycle=%0d",
                 v.a, v.b, v.sgn, out_Hi, out_Lo, done_cyc);
        @(posedge clk); #1;
        check("idle_done_low", {62'd0, out_Done, out_Busy}, 64'd0);
        check("hold_result", {out_Hi, out_Lo}, {v.exp_hi, v.exp_lo});
    endtask

    task automatic add_vec(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic sgn,
                           input logic inject, input logic [NB-1:0] hi, input logic [NB-1:0] lo);
        vec_t v;
        v.a = a; v.b = b; v.sgn = sgn; v.inject = inject;
        v.exp_hi = hi; v.exp_lo = lo;
        vecs.push_back(v);
    endtask

    initial begin
        int ndone;
        vec_t v;

        reset           = 1'b1;
        in_Start        = 1'b0;
        in_Multiplicand = '0;
        in_Multiplier   = '0;
`ifdef MULT_SIGNED_EN
        in_Signed       = 1'b0;
`endif

        add_vec(32'd3,        32'd5,        1'b0, 1'b0, 32'h0,        32'hF);
        add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h1);
        add_vec(32'd7,        32'd9,        1'b0, 1'b1, 32'h0,        32'h3F);
        add_vec(32'd0,        32'h12345678, 1'b0, 1'b0, 32'h0,        32'h0);
        add_vec(32'd1,        32'h80000000, 1'b0, 1'b0, 32'h0,        32'h80000000);
        add_vec(32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'h0,        32'hFFFE0001);
        add_vec(32'h80000000, 32'd2,        1'b0, 1'b0, 32'h1,        32'h0);
`ifdef MULT_SIGNED_EN
        add_vec(32'hFFFFFFFD, 32'd5,        1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        add_vec(32'd7,        32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9);
        add_vec(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 1'b0, 32'h0,        32'h6);
        add_vec(32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'h4,        32'hFFFFFFF1);
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_done", {62'd0, out_Done, out_Busy}, 64'd0);
        check("reset_hilo", {out_Hi, out_Lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table vectors, back to back (each start lands in the first IDLE
        // cycle after the previous DONE)
        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in cycle 10 of 6 x 7
        drive_start(32'd6, 32'd7, 1'b0);
        @(posedge clk); #1;
        in_Start = 1'b0;
        for (int cyc = 2; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", {63'd0, out_Busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy_done", {62'd0, out_Done, out_Busy}, 64'd0);
        check("abort_hilo", {out_Hi, out_Lo}, 64'd0);
        $display("abort 6 x 7 in cycle 10 -> busy=%0d hi=%08h lo=%08h", out_Busy, out_Hi, out_Lo);
        ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_Done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        v.a = 32'd2; v.b = 32'd2; v.sgn = 1'b0; v.inject = 1'b0;
        v.exp_hi = 32'h0; v.exp_lo = 32'h4;
        run_op(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 SHALL have parameter NBits, default 32, operand width.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_Start, input, 1, request to begin a multiply.
REQ-005 SHALL have port in_Multiplicand, input, NBits, operand A, sampled on accepted start.
REQ-006 SHALL have port in_Multiplier, input, NBits, operand B, sampled on accepted start.
REQ-007 SHALL have port out_Busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port out_Done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port out_Hi, output, NBits, upper half of the 2*NBits product.
REQ-010 SHALL have port out_Lo, output, NBits, lower half of the 2*NBits product.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-012 SHALL accept in_Start only in IDLE; start edge = cycle 0: latch operands, clear Hi, load Lo = multiplier, counter = 0, go to RUN.
REQ-013 SHALL ignore in_Start in RUN, FIX and DONE, with no effect on state or operands.
REQ-014 SHALL, each RUN cycle, form sum = {0,Hi} + (Lo[0] ? {0,multiplicand} : 0) at NBits+1 bits, then load {Hi,Lo} = {sum,Lo} >> 1 (carry shifted into Hi MSB).
REQ-015 SHALL leave RUN after exactly NBits iterations; next state FIX if signed op active, else DONE.
REQ-016 SHALL assert out_Busy in RUN and FIX only; low in IDLE and DONE.
REQ-017 SHALL assert out_Done for exactly the one DONE cycle, then return to IDLE.
REQ-018 SHALL give unsigned latency: out_Done high in cycle NBits+1 after the start edge.
REQ-019 SHALL hold out_Hi/out_Lo valid from DONE until the next accepted start; values during RUN/FIX are don't-care to consumers.
REQ-020 SHALL allow back-to-back ops: start asserted in the first IDLE cycle after DONE is accepted.
REQ-021 SHALL treat zero operands as normal: full NBits iterations, product 0, no early exit.

Reset
REQ-022 SHALL, on reset high at any clock edge (including mid-RUN/FIX), go to IDLE and clear counter, out_Busy=0, out_Done=0, out_Hi=0, out_Lo=0.
REQ-023 SHALL never emit out_Done for an operation aborted by reset.

Configuration
REQ-024 SHALL use macro MULT_SIGNED_EN.
REQ-025 SHALL, with MULT_SIGNED_EN defined, add port in_Signed (input, 1, sampled on accepted start); when 1, operands are two's-complement, magnitudes are multiplied, and FIX negates {Hi,Lo} (2*NBits two's complement) if operand signs differ; FIX always lasts one cycle for signed ops, giving out_Done in cycle NBits+2.
REQ-026 SHALL, without MULT_SIGNED_EN, omit in_Signed and FIX logic; all ops unsigned, FIX unreachable.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/RUN/FIX/DONE) and the counter-width constant (clog2(NBits)+1) in shared package mult_pkg.
REQ-028 SHALL instantiate one Adder32bits, with NBits parameter set to NBits+1, as the only iteration adder; no other adder in RUN.

Verification
REQ-029 SHALL cover: 3 x 5 unsigned, start at cycle 0 -> out_Done only in cycle 33, Hi=0x00000000, Lo=0x0000000F.
REQ-030 SHALL cover: 0xFFFFFFFF x 0xFFFFFFFF unsigned -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-031 SHALL cover: 7 x 9 started, then in_Start with 2 x 2 in cycle 5 -> ignored; result Hi=0, Lo=0x0000003F in cycle 33.
REQ-032 SHALL cover: reset high in cycle 10 of 6 x 7 -> cycle 11: IDLE, Busy=0, Hi=Lo=0; no out_Done; a subsequent 2 x 2 gives Lo=4.
REQ-033 SHALL cover: MULT_SIGNED_EN, in_Signed=1, -3 x 5 -> out_Done in cycle 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
REQ-034 SHALL cover: back-to-back 0 x 0x12345678 then 1 x 0x80000000 -> Lo=0, then Hi=0, Lo=0x80000000; Done pulses exactly one cycle each.
